// File: rtl/squaremeas.sv
// Square-wave / PPS period meter: measures rise-to-rise period and high time of an
// asynchronous input, publishes each measurement with a strobe, tracks lock and loss of signal.
module squaremeas #(
   parameter int unsigned lock_count = 4,
   parameter int unsigned tolerance  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sq_i,
   input  logic [31:0] timeout,
   output logic [31:0] period_o,
   output logic [31:0] high_o,
   output logic        valid_o,
   output logic        locked_o,
   output logic        lost_o
);

   localparam logic [3:0]  LOCK_CNT = 4'(lock_count);
   localparam logic [32:0] TOL      = 33'(tolerance);

   typedef enum logic {SEEK, RUN} state_t;

   state_t             state, state_nxt;
   logic               s1, s2, s3;
   logic               rise, fall;
   logic [31:0]        cnt, high_sh, prev;
   logic [3:0]         match, match_nxt;
   logic               have_prev;
   logic               publish, expire, in_tol, mismatch;
   logic signed [32:0] diff;
   logic [32:0]        diff_abs;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [32:0] abs33(input logic signed [32:0] d);
      logic signed [32:0] n;
      n = -d;
      return (d < 0) ? $unsigned(n) : $unsigned(d);
   endfunction

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   // Period comparison is done in 33-bit signed so the full 32-bit count range never wraps.
   assign diff     = $signed({1'b0, cnt}) - $signed({1'b0, prev});
   assign diff_abs = abs33(diff);
   assign in_tol   = (diff_abs <= TOL);
   assign mismatch = publish & have_prev & ~in_tol;

   always_comb begin
      state_nxt = state;
      publish   = 1'b0;
      expire    = 1'b0;
      case (state)
         SEEK: begin
            if (rise) state_nxt = RUN;
         end
         RUN: begin
            // A rise in the expiry cycle wins over the timeout.
            if (rise) begin
               publish = 1'b1;
            end else if ((timeout != 32'd0) && (cnt >= timeout)) begin
               expire    = 1'b1;
               state_nxt = SEEK;
            end
         end
      endcase
   end

   always_comb begin
      match_nxt = match;
      if (expire) begin
         match_nxt = 4'd0;
      end else if (publish && have_prev) begin
         if (!in_tol)                match_nxt = 4'd0;
         else if (match != LOCK_CNT) match_nxt = match + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         state     <= SEEK;
         cnt       <= 32'd0;
         high_sh   <= 32'd0;
         prev      <= 32'd0;
         match     <= 4'd0;
         have_prev <= 1'b0;
         period_o  <= 32'd0;
         high_o    <= 32'd0;
         valid_o   <= 1'b0;
         locked_o  <= 1'b0;
         lost_o    <= 1'b0;
      end else begin
         s1      <= sq_i;
         s2      <= s1;
         s3      <= s2;
         state   <= state_nxt;
         valid_o <= publish;
         lost_o  <= expire;
         match   <= match_nxt;

         if (rise) cnt <= 32'd1;
         else      cnt <= sat_inc(cnt);

         if (rise && (state == SEEK)) high_sh <= 32'd0;
         else if (fall)               high_sh <= cnt;

         if (publish) begin
            period_o  <= cnt;
            high_o    <= high_sh;
            prev      <= cnt;
            have_prev <= 1'b1;
         end else if (expire) begin
            have_prev <= 1'b0;
         end

         // Lock follows the registered match count, but drops at once on a bad period or loss.
         if (expire || mismatch) locked_o <= 1'b0;
         else                    locked_o <= (match == LOCK_CNT);
      end
   end

endmodule

// File: tb/tb_squaremeas.sv
// Bench for squaremeas: event-level reference model checked every cycle, a table of
// steady waveforms, hand sequences for jitter, loss, race and reset, then random traffic.
module tb_squaremeas;

   localparam int LC  = 4;
   localparam int TOL = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sq_i = 1'b0;
   logic [31:0] timeout = 32'd0;
   logic [31:0] period_o, high_o;
   logic        valid_o, locked_o, lost_o;

   squaremeas #(.lock_count(LC), .tolerance(TOL)) dut (
      .clk(clk), .rst_n(rst_n), .sq_i(sq_i), .timeout(timeout),
      .period_o(period_o), .high_o(high_o), .valid_o(valid_o),
      .locked_o(locked_o), .lost_o(lost_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: works on edge numbers of detected rises/falls, not on DUT registers.
   int  e = 0;
   bit  hist[$];
   bit  m_run, m_have_prev;
   int  m_last, m_high, m_prevp, m_match;
   bit  x_valid, x_lost, x_locked;
   logic [31:0] x_period, x_high;

   // Scenario observations
   int  n_valid, n_lost;
   bit  saw_locked, lost_locked;
   logic [31:0] lost_period;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
      end
   endtask

   task automatic model_reset();
      hist = '{1'b0, 1'b0, 1'b0};
      m_run = 0; m_have_prev = 0; m_last = 0; m_high = 0; m_prevp = 0; m_match = 0;
      x_valid = 0; x_lost = 0; x_locked = 0; x_period = 0; x_high = 0;
   endtask

   task automatic model_step();
      bit r, f, lk;
      int per, d;
      e++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      hist.push_back(sq_i);
      if (hist.size() > 4) void'(hist.pop_front());
      // Sample taken two edges ago is what shows up in this edge's outputs.
      r = hist[1] && !hist[0];
      f = !hist[1] && hist[0];
      x_valid = 0;
      x_lost  = 0;
      lk = (m_match == LC);
      if (!m_run) begin
         if (r) begin
            m_run = 1; m_last = e; m_high = 0;
         end
      end else if (r) begin
         per = e - m_last;
         x_valid = 1; x_period = 32'(per); x_high = 32'(m_high);
         if (m_have_prev) begin
            d = per - m_prevp;
            if (d < 0) d = -d;
            if (d <= TOL) m_match = (m_match < LC) ? m_match + 1 : LC;
            else begin m_match = 0; lk = 0; end
         end
         m_prevp = per; m_have_prev = 1; m_last = e;
      end else begin
         if (f) m_high = e - m_last;
         if (timeout != 0 && longint'(e - m_last) >= longint'(timeout)) begin
            x_lost = 1; m_run = 0; m_match = 0; m_have_prev = 0; lk = 0;
         end
      end
      x_locked = lk;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("valid_o",  {31'b0, valid_o},  {31'b0, x_valid});
      chk("lost_o",   {31'b0, lost_o},   {31'b0, x_lost});
      chk("locked_o", {31'b0, locked_o}, {31'b0, x_locked});
      chk("period_o", period_o, x_period);
      chk("high_o",   high_o,   x_high);
      if (valid_o) n_valid++;
      if (lost_o) begin
         n_lost++; lost_locked = locked_o; lost_period = period_o;
      end
      if (locked_o) saw_locked = 1;
   endtask

   task automatic clear_obs();
      n_valid = 0; n_lost = 0; saw_locked = 0; lost_locked = 1; lost_period = 32'hDEAD;
   endtask

   task automatic do_reset();
      sq_i = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic run_wave(input int per, input int hi, input int reps);
      for (int r = 0; r < reps; r++)
         for (int c = 0; c < per; c++) begin
            sq_i = (c < hi);
            tick();
         end
   endtask

   task automatic run_periods(input int p[$], input int hi);
      foreach (p[i]) run_wave(p[i], hi, 1);
   endtask

   typedef struct {
      int          per;
      int          hi;
      int          reps;
      logic [31:0] tmo;
      logic [31:0] exp_per;
      logic [31:0] exp_hi;
      bit          exp_lock;
      int          exp_valid;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int q[$];
      int lost_tick;
      int base, p, h, sel;

      vecs[0] = '{20, 10, 8, 32'd0,  32'd20, 32'd10, 1'b1, 7};
      vecs[1] = '{3,  1,  8, 32'd0,  32'd3,  32'd1,  1'b1, 7};
      vecs[2] = '{7,  6,  8, 32'd0,  32'd7,  32'd6,  1'b1, 7};
      vecs[3] = '{50, 1,  7, 32'd0,  32'd50, 32'd1,  1'b1, 6};
      vecs[4] = '{20, 10, 6, 32'd20, 32'd20, 32'd10, 1'b1, 5};

      model_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      chk("reset_period", period_o, 32'd0);
      chk("reset_valid",  {31'b0, valid_o}, 32'd0);
      rst_n = 1'b1;

      // Steady waveforms (last entry: timeout equal to the period, rise must win)
      for (int i = 0; i < 5; i++) begin
         do_reset();
         timeout = vecs[i].tmo;
         clear_obs();
         run_wave(vecs[i].per, vecs[i].hi, vecs[i].reps);
         chk("tbl_period", period_o, vecs[i].exp_per);
         chk("tbl_high",   high_o,   vecs[i].exp_hi);
         chk("tbl_locked", {31'b0, locked_o}, {31'b0, vecs[i].exp_lock});
         chk("tbl_nvalid", 32'(n_valid), 32'(vecs[i].exp_valid));
         chk("tbl_nlost",  32'(n_lost), 32'd0);
      end

      // Jitter beyond tolerance: never locks
      do_reset(); timeout = 0; clear_obs();
      q = '{20, 21, 19, 21, 26, 20};
      run_periods(q, 5);
      chk("jit_locked", {31'b0, saw_locked}, 32'd0);
      chk("jit_period", period_o, 32'd26);
      chk("jit_nvalid", 32'(n_valid), 32'd5);

      // Differences exactly at tolerance: locks
      do_reset(); timeout = 0; clear_obs();
      q = '{20, 22, 20, 22, 20, 22, 20};
      run_periods(q, 5);
      chk("tolb_locked", {31'b0, saw_locked}, 32'd1);

      // Loss of signal after lock
      do_reset(); timeout = 32'd100; clear_obs();
      run_wave(20, 10, 8);
      chk("loss_prelock", {31'b0, locked_o}, 32'd1);
      clear_obs();
      sq_i = 1'b0;
      lost_tick = -1;
      for (int i = 1; i <= 200 && lost_tick < 0; i++) begin
         tick();
         if (lost_o) lost_tick = i;
      end
      repeat (5) tick();
      chk("loss_latency", 32'(lost_tick), 32'd83);
      chk("loss_count",   32'(n_lost), 32'd1);
      chk("loss_locked",  {31'b0, lost_locked}, 32'd0);
      chk("loss_period",  lost_period, 32'd20);
      clear_obs();
      run_wave(20, 10, 3);
      chk("restart_nvalid", 32'(n_valid), 32'd2);

      // Reset while locked, input high at release
      do_reset(); timeout = 0;
      run_wave(20, 10, 8);
      sq_i = 1'b1; rst_n = 1'b0;
      tick();
      chk("rst_period", period_o, 32'd0);
      chk("rst_high",   high_o, 32'd0);
      chk("rst_locked", {31'b0, locked_o}, 32'd0);
      chk("rst_valid",  {31'b0, valid_o}, 32'd0);
      chk("rst_lost",   {31'b0, lost_o}, 32'd0);
      rst_n = 1'b1; clear_obs();
      repeat (10) tick();
      sq_i = 1'b0;
      repeat (10) tick();
      chk("rst_novalid", 32'(n_valid), 32'd0);
      run_wave(20, 10, 2);
      chk("rst_nvalid2", 32'(n_valid), 32'd2);
      chk("rst_period2", period_o, 32'd20);

      // Random traffic around a drifting base period
      do_reset(); timeout = 0;
      base = 20;
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 19);
         if (sel == 0) timeout = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(5, 60));
         if (sel == 1) begin rst_n = 1'b0; tick(); rst_n = 1'b1; end
         if (sel == 2) base = $urandom_range(6, 40);
         if (sel == 3) begin sq_i = 1'b0; repeat ($urandom_range(40, 80)) tick(); end
         p = base + $urandom_range(0, 6) - 3;
         h = $urandom_range(1, p - 1);
         run_wave(p, h, 1);
      end
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
